// File: rtl/serial_word_cmp.sv
// Sequential unsigned comparator for wide words: one 4-bit slice per clock, MSB slice first,
// all slices resolved by a single shared four_bc instance.

module four_bc (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       k,
  output logic       l,
  output logic       m
);

  assign k = (a > b);
  assign l = (a == b);
  assign m = (a < b);

endmodule

module serial_word_cmp #(
  parameter int NIBBLES    = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic                 gt,
  output logic                 eq,
  output logic                 lt
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IW-1:0]   idx;
  logic [3:0]      a_sl;
  logic [3:0]      b_sl;
  logic            k;
  logic            l;
  logic            m;
  logic            st_valid;
  logic            st_gt;
  logic            st_lt;

  // Explicit mux over legal slice positions keeps the select in range for every NIBBLES.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[4*i +: 4];
        b_sl = b_q[4*i +: 4];
      end
    end
  end

  four_bc u_bc (
    .a (a_sl),
    .b (b_sl),
    .k (k),
    .l (l),
    .m (m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      st_valid <= 1'b0;
      st_gt    <= 1'b0;
      st_lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            idx      <= IW'(NIBBLES - 1);
            st_valid <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          if (!l && (EARLY_EXIT != 0)) begin
            gt    <= k;
            eq    <= 1'b0;
            lt    <= m;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (idx == '0) begin
            // The earliest unequal slice owns the ordering; the last slice only decides if none did.
            if (st_valid) begin
              gt <= st_gt;
              eq <= 1'b0;
              lt <= st_lt;
            end else begin
              gt <= k;
              eq <= l;
              lt <= m;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            if (!l && !st_valid) begin
              st_valid <= 1'b1;
              st_gt    <= k;
              st_lt    <= m;
            end
            idx <= idx - 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
